// File: rtl/approx_adder_pipe_eval.sv
// rtl/approx_adder_pipe_eval.sv - pipelined approximate adder with on-line error statistics
module approx_adder_pipe_eval #(
  parameter int W     = 16,
  parameter int KW    = 5,
  parameter int CNT_W = 32,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_mode,
  input  logic [KW-1:0]    in_keep,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  output logic [W:0]       out_exact,
  input  logic             clear,
  output logic [CNT_W-1:0] st_samples,
  output logic [CNT_W-1:0] st_errcnt,
  output logic [ACC_W-1:0] st_errsum,
  output logic [W:0]       st_errmax
);

  localparam int RW = W + 1;
  localparam logic [KW-1:0] KEEP_MAX = KW'(RW);

  logic          s1_valid;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic [1:0]    s1_mode;
  logic [KW-1:0] s1_keep;
  logic [RW-1:0] s2_err;

  logic          s2_en;
  logic          accept;
  logic          retire;
  logic [KW-1:0] keep_c;
  logic [KW-1:0] t;
  logic [RW-1:0] exact;
  logic [RW-1:0] mask;
  logic [RW-1:0] approx;
  logic [ACC_W:0] errsum_next;

  // S2 can take a new beat when it is empty or its current beat retires this cycle
  assign s2_en    = !out_valid || out_ready;
  // S1 only blocks when it is full and cannot drain into a stalled S2
  assign in_ready = !(s1_valid && !s2_en);
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;

  // Clamp keep into 1..W+1 at capture so the datapath only ever sees legal values
  always_comb begin
    keep_c = in_keep;
    if (in_keep == '0) begin
      keep_c = KW'(1);
    end else if (in_keep > KEEP_MAX) begin
      keep_c = KEEP_MAX;
    end
  end

  // Approximate sum from the S1 beat: t low bits are dropped or computed without carry
  always_comb begin
    t      = KEEP_MAX - s1_keep;
    exact  = {1'b0, s1_a} + {1'b0, s1_b};
    mask   = ~((RW'(1) << t) - RW'(1));
    approx = exact;
    case (s1_mode)
      2'd1:    approx = exact & mask;
      2'd2:    approx = (({1'b0, s1_a} >> t) + ({1'b0, s1_b} >> t)) << t;
      default: approx = exact;
    endcase
  end

  // Stage 1: operand and per-beat config capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
      s1_keep  <= KEEP_MAX;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_mode <= in_mode;
        s1_keep <= keep_c;
      end
    end
  end

  // Stage 2: result register, held stable while stalled downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_exact <= '0;
      s2_err    <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum   <= approx;
        out_exact <= exact;
        s2_err    <= exact - approx;
      end
    end
  end

  assign errsum_next = {1'b0, st_errsum} + (ACC_W + 1)'(s2_err);

  // Saturating statistics, updated on retire; clear takes priority over a same-cycle retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_samples <= '0;
      st_errcnt  <= '0;
      st_errsum  <= '0;
      st_errmax  <= '0;
    end else if (clear) begin
      st_samples <= '0;
      st_errcnt  <= '0;
      st_errsum  <= '0;
      st_errmax  <= '0;
    end else if (retire) begin
      if (st_samples != '1) begin
        st_samples <= st_samples + CNT_W'(1);
      end
      if ((s2_err != '0) && (st_errcnt != '1)) begin
        st_errcnt <= st_errcnt + CNT_W'(1);
      end
      st_errsum <= errsum_next[ACC_W] ? '1 : errsum_next[ACC_W-1:0];
      if (s2_err > st_errmax) begin
        st_errmax <= s2_err;
      end
    end
  end

endmodule

// File: tb/tb_approx_adder_pipe_eval.sv
// tb/tb_approx_adder_pipe_eval.sv - directed self-checking bench for approx_adder_pipe_eval
module tb_approx_adder_pipe_eval;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [1:0]  in_mode;
  logic [4:0]  in_keep;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_sum;
  logic [16:0] out_exact;
  logic        clear;
  logic [31:0] st_samples;
  logic [31:0] st_errcnt;
  logic [17:0] st_errsum;
  logic [16:0] st_errmax;

  int checks = 0;
  int errors = 0;

  approx_adder_pipe_eval #(.W(16), .KW(5), .CNT_W(32), .ACC_W(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_keep(in_keep),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_exact(out_exact),
    .clear(clear),
    .st_samples(st_samples), .st_errcnt(st_errcnt),
    .st_errsum(st_errsum), .st_errmax(st_errmax)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat through an otherwise empty pipe with out_ready high; ends one cycle after retire
  task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] m, input logic [4:0] k,
                          input logic [16:0] es, input logic [16:0] ee);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = m; in_keep = k; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_v1"}, out_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_v2"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_exact"}, out_exact, ee);
    @(negedge clk);
    #1;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  logic [15:0] ta [8] = '{16'h0001, 16'h1234, 16'h8000, 16'hFFFF, 16'h00FF, 16'hABCD, 16'h7FFF, 16'h5555};
  logic [15:0] tb [8] = '{16'h0002, 16'h1111, 16'h8000, 16'hFFFF, 16'h0001, 16'h1111, 16'h0001, 16'hAAAA};
  logic [16:0] te [8] = '{17'h00003, 17'h02345, 17'h10000, 17'h1FFFE, 17'h00100, 17'h0BCDE, 17'h08000, 17'h0FFFF};
  logic [3:0]  rpat   = 4'b1001;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sidx;
    int ridx;
    int inflight;
    int cyc;
    logic acc;
    logic ret;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; in_keep = '0;
    out_ready = 1'b1; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_exact", out_exact, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_samples", st_samples, 0);
    chk("rst_errsum", st_errsum, 0);
    @(negedge clk); rst_n = 1'b1;

    // exact mode with carry out of the MSB
    send_one("t1", 16'hFFFF, 16'h0001, 2'd0, 5'd3, 17'h10000, 17'h10000);
    chk("t1_samples", st_samples, 1);
    chk("t1_errcnt", st_errcnt, 0);

    // truncate with exact carry
    send_one("t2a", 16'hFFFF, 16'h0001, 2'd1, 5'd3, 17'h10000, 17'h10000);
    chk("t2a_errsum", st_errsum, 0);
    send_one("t2b", 16'h3FFF, 16'h0000, 2'd1, 5'd3, 17'h00000, 17'h03FFF);
    chk("t2b_errsum", st_errsum, 18'h03FFF);
    chk("t2b_errcnt", st_errcnt, 1);
    chk("t2b_samples", st_samples, 3);

    // truncate with carry-in 0
    do_clear();
    #1 chk("clr_samples", st_samples, 0);
    send_one("t3", 16'hFFFF, 16'h0001, 2'd2, 5'd3, 17'h0C000, 17'h10000);
    chk("t3_errmax", st_errmax, 17'h04000);
    chk("t3_errcnt", st_errcnt, 1);
    chk("t3_errsum", st_errsum, 18'h04000);

    // keep clamping and reserved mode
    send_one("k0", 16'h00FF, 16'h0001, 2'd1, 5'd0, 17'h00000, 17'h00100);
    send_one("k31", 16'h1234, 16'h4321, 2'd2, 5'd31, 17'h05555, 17'h05555);
    send_one("m3", 16'hFFFF, 16'h0001, 2'd3, 5'd1, 17'h10000, 17'h10000);
    chk("clamp_errsum", st_errsum, 18'h04100);
    chk("clamp_errcnt", st_errcnt, 2);

    // streaming with out_ready pattern 1,0,0,1
    do_clear();
    sidx = 0; ridx = 0; inflight = 0; cyc = 0;
    while ((ridx < 8) && (cyc < 80)) begin
      @(negedge clk);
      in_valid  = (sidx < 8);
      in_a      = ta[sidx % 8];
      in_b      = tb[sidx % 8];
      in_mode   = 2'd0;
      in_keep   = 5'd17;
      out_ready = rpat[3 - (cyc % 4)];
      #1;
      chk("st_in_ready", in_ready, !((inflight == 2) && !out_ready));
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
        chk("st_sum", out_sum, te[ridx]);
        chk("st_exact", out_exact, te[ridx]);
        ridx++;
      end
      if (acc) begin
        sidx++;
        inflight++;
      end
      if (ret) inflight--;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("st_retired", ridx, 8);
    @(negedge clk);
    #1;
    chk("st_out_valid_idle", out_valid, 0);
    chk("st_samples", st_samples, 8);
    chk("st_errcnt", st_errcnt, 0);

    // errsum saturation (ACC_W=18, all-ones=0x3FFFF)
    do_clear();
    send_one("s1", 16'hFFFF, 16'hFFFF, 2'd2, 5'd1, 17'h00000, 17'h1FFFE);
    send_one("s2", 16'hFFFF, 16'hFFFF, 2'd2, 5'd1, 17'h00000, 17'h1FFFE);
    send_one("s3", 16'h0001, 16'h0001, 2'd2, 5'd16, 17'h00000, 17'h00002);
    chk("sat_pre", st_errsum, 18'h3FFFE);
    send_one("s4", 16'h0003, 16'h0002, 2'd2, 5'd15, 17'h00000, 17'h00005);
    chk("sat_hit", st_errsum, 18'h3FFFF);
    send_one("s5", 16'h0001, 16'h0000, 2'd2, 5'd16, 17'h00000, 17'h00001);
    chk("sat_hold", st_errsum, 18'h3FFFF);
    chk("sat_errmax", st_errmax, 17'h1FFFE);
    chk("sat_errcnt", st_errcnt, 5);
    chk("sat_samples", st_samples, 5);

    // clear coinciding with a retire
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'h0007; in_b = 16'h0001; in_mode = 2'd1; in_keep = 5'd10;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("cr_out_valid", out_valid, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("cr_samples", st_samples, 0);
    chk("cr_errcnt", st_errcnt, 0);
    chk("cr_errsum", st_errsum, 0);
    chk("cr_errmax", st_errmax, 0);
    chk("cr_retired", out_valid, 0);

    // async reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'h0100; in_b = 16'h0200; in_mode = 2'd0; in_keep = 5'd17;
    @(negedge clk);
    in_a = 16'h0300;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("ar_full_valid", out_valid, 1);
    chk("ar_full_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_sum", out_sum, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_samples", st_samples, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_one("ar_new", 16'h1000, 16'h0234, 2'd0, 5'd17, 17'h01234, 17'h01234);
    chk("ar_new_samples", st_samples, 1);
    chk("ar_no_ghost", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
